gf571_reduce: RTL

- Modular reduction stage placed directly downstream of the 571x571 GF(2) polynomial multiplier.
- Consumes the 1142-bit unreduced product and reduces it modulo the NIST B-571 pentanomial f(x) = x^571 + x^10 + x^5 + x^2 + 1.
- Returns a 571-bit field element.
- Iterative two-fold datapath under a small FSM, with valid/ready handshakes on both sides, so it can be placed between the multiplier and the point-arithmetic controller.

---
 rtl/gf571_pkg.sv | 20 ++
 rtl/gf571_fold.sv | 24 ++
 rtl/gf571_reduce.sv | 112 +++++++++++
 3 files changed

// File: rtl/gf571_pkg.sv
// Shared constants, reduction taps and FSM state type for the B-571 reduction stage.
// f(x) = x^571 + x^10 + x^5 + x^2 + 1
package gf571_pkg;

  localparam int M      = 571;
  localparam int PROD_W = 2 * M;
  localparam int PART_W = M + 10;

  // Low-order exponents of f(x); x^571 folds onto x^10 + x^5 + x^2 + 1.
  localparam int NTAPS = 4;
  localparam int TAPS [NTAPS] = '{10, 5, 2, 0};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FOLD1 = 2'd1,
    S_FOLD2 = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/gf571_fold.sv
// Combinational fold: lo ^ sum over taps t of (hi << t), for a high part of any width.
module gf571_fold
  import gf571_pkg::*;
#(
  parameter int HW    = M,
  parameter int OUT_W = PART_W
) (
  input  logic [HW-1:0]    hi,
  input  logic [M-1:0]     lo,
  output logic [OUT_W-1:0] folded
);

  logic [OUT_W-1:0] hi_ext;

  assign hi_ext = OUT_W'(hi);

  always_comb begin
    folded = OUT_W'(lo);
    for (int t = 0; t < NTAPS; t++) begin
      folded = folded ^ (hi_ext << TAPS[t]);
    end
  end

endmodule

// File: rtl/gf571_reduce.sv
// Two-pass reduction of an unreduced 1142-bit GF(2) product modulo the B-571 pentanomial,
// with valid/ready on both sides. First pass leaves at most 10 bits above x^570, second clears them.
module gf571_reduce #(
  parameter int M = 571
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-1:0] in_d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   out_r
);

  import gf571_pkg::*;

  if (M != 571) begin : g_bad_m
    $error("gf571_reduce: only M=571 is supported");
  end

  state_e              state_q, state_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [PART_W-1:0]   part_q, part_d;
  logic [M-1:0]        out_r_q, out_r_d;
  logic                out_valid_q, out_valid_d;

  logic [PART_W-1:0]   fold1_p;
  logic [M-1:0]        fold2_r;
  logic                accept;

  gf571_fold #(
    .HW    (M),
    .OUT_W (PART_W)
  ) u_fold1 (
    .hi     (prod_q[PROD_W-1:M]),
    .lo     (prod_q[M-1:0]),
    .folded (fold1_p)
  );

  // Second pass: the 10-bit overflow lands at degree <= 19, so M bits suffice.
  gf571_fold #(
    .HW    (PART_W - M),
    .OUT_W (M)
  ) u_fold2 (
    .hi     (part_q[PART_W-1:M]),
    .lo     (part_q[M-1:0]),
    .folded (fold2_r)
  );

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;

  always_comb begin
    state_d     = state_q;
    prod_d      = prod_q;
    part_d      = part_q;
    out_r_d     = out_r_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          prod_d  = in_d;
          state_d = S_FOLD1;
        end
      end
      S_FOLD1: begin
        part_d  = fold1_p;
        state_d = S_FOLD2;
      end
      S_FOLD2: begin
        out_r_d     = fold2_r;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            prod_d  = in_d;
            state_d = S_FOLD1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prod_q      <= '0;
      part_q      <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prod_q      <= prod_d;
      part_q      <= part_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
